// File: rtl/buzzer_seq.sv
// Multi-channel prioritised alarm sounder for a DC buzzer.
// Beep pattern ON/OFF x BEEPS then GAP; continuous channels, preemption and auto-silence.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | nothing sounding, prescaler held at 0
// ON    | buzzer driven high for ON_MS ticks
// OFF   | buzzer low between beeps for OFF_MS ticks
// GAP   | silence after a full burst for GAP_MS ticks
module buzzer_seq #(
  parameter int NUM_CH     = 2,
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int ON_MS      = 400,
  parameter int OFF_MS     = 400,
  parameter int BEEPS      = 3,
  parameter int GAP_MS     = 1000,
  parameter int TIMEOUT_MS = 60000,
  parameter logic [NUM_CH-1:0] CONT_MASK = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              btn_clear,
  output logic              buzz,
  output logic [NUM_CH-1:0] active,
  output logic              busy
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] PRESC_TC = DIV_W'(DIV - 1);
  localparam logic [15:0] ON_LD  = 16'(ON_MS - 1);
  localparam logic [15:0] OFF_LD = 16'(OFF_MS - 1);
  localparam logic [15:0] GAP_LD = 16'(GAP_MS - 1);
  localparam logic [31:0] TMO_LD = (TIMEOUT_MS > 0) ? 32'(TIMEOUT_MS - 1) : 32'd0;
  localparam logic [8:0]  BEEPS_N = 9'(BEEPS);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} state_t;

  state_t             state, state_nxt;
  logic [NUM_CH-1:0]  pending, pending_nxt;
  logic [NUM_CH-1:0]  req_d;
  logic [NUM_CH-1:0]  active_nxt;
  logic [7:0]         beep_cnt, beep_nxt;
  logic [15:0]        phase, phase_nxt;
  logic [31:0]        tmo, tmo_nxt;
  logic [DIV_W-1:0]   presc, presc_nxt;

  logic [NUM_CH-1:0]  rise, cand, sel_oh;
  logic               tick, expire, cont_act, do_start;
  logic [8:0]         beep_inc;

  assign rise     = req & ~req_d;
  assign cand     = pending | rise;
  assign tick     = (state != ST_IDLE) && (presc == PRESC_TC);
  assign expire   = (TIMEOUT_MS != 0) && tick && (tmo == 32'd0);
  assign cont_act = |(active & CONT_MASK);
  assign beep_inc = {1'b0, beep_cnt} + 9'd1;

  // Ascending scan: the highest set index wins.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cand[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending | rise;
    active_nxt  = active;
    beep_nxt    = beep_cnt;
    phase_nxt   = phase;
    tmo_nxt     = tmo;
    do_start    = 1'b0;

    if (state == ST_IDLE || tick) presc_nxt = '0;
    else                          presc_nxt = presc + 1'b1;
    if (tick && tmo != 32'd0)   tmo_nxt   = tmo - 32'd1;
    if (tick && phase != 16'd0) phase_nxt = phase - 16'd1;

    if (btn_clear) begin
      pending_nxt = '0;
      state_nxt   = ST_IDLE;
      active_nxt  = '0;
      beep_nxt    = '0;
      phase_nxt   = '0;
      tmo_nxt     = '0;
      presc_nxt   = '0;
    end else if (state == ST_IDLE) begin
      do_start = |cand;
    end else begin
      if (expire) pending_nxt = pending_nxt & ~active;
      // The active channel stays pending, so a different winner means a higher arm.
      if (sel_oh != active) begin
        do_start = 1'b1;
      end else if (expire) begin
        state_nxt  = ST_IDLE;
        active_nxt = '0;
        beep_nxt   = '0;
        phase_nxt  = '0;
        tmo_nxt    = '0;
      end else if (tick && phase == 16'd0) begin
        case (state)
          ST_ON: begin
            state_nxt = ST_OFF;
            phase_nxt = OFF_LD;
          end
          ST_OFF: begin
            beep_nxt = beep_inc[7:0];
            if (cont_act || beep_inc < BEEPS_N) begin
              state_nxt = ST_ON;
              phase_nxt = ON_LD;
            end else begin
              state_nxt = ST_GAP;
              phase_nxt = GAP_LD;
            end
          end
          ST_GAP: begin
            state_nxt = ST_ON;
            beep_nxt  = '0;
            phase_nxt = ON_LD;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end

    if (do_start) begin
      state_nxt  = ST_ON;
      active_nxt = sel_oh;
      beep_nxt   = '0;
      phase_nxt  = ON_LD;
      tmo_nxt    = TMO_LD;
      presc_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      pending  <= '0;
      req_d    <= '1;
      active   <= '0;
      beep_cnt <= '0;
      phase    <= '0;
      tmo      <= '0;
      presc    <= '0;
      buzz     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      req_d    <= req;
      active   <= active_nxt;
      beep_cnt <= beep_nxt;
      phase    <= phase_nxt;
      tmo      <= tmo_nxt;
      presc    <= presc_nxt;
      buzz     <= (state_nxt == ST_ON);
      busy     <= |pending_nxt;
    end
  end

endmodule
